bcd_display_scan: RTL and testbench



---
 rtl/bcd_disp_pkg.sv | 17 +
 rtl/seg7_decode.sv | 26 ++
 rtl/bcd_display_scan.sv | 108 ++++++++++
 tb/tb_bcd_display_scan.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// rtl/bcd_disp_pkg.sv - shared scan states, segment/anode constants and nibble check
package bcd_disp_pkg;

  typedef enum logic [1:0] {ONES, GAP_A, TENS, GAP_B} scan_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  localparam logic [1:0] AN_OFF  = 2'b11;
  localparam logic [1:0] AN_ONES = 2'b10;
  localparam logic [1:0] AN_TENS = 2'b01;

  function automatic logic nib_bad(input logic [3:0] nib);
    return nib > 4'd9;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - BCD nibble to {g,f,e,d,c,b,a} pattern, dash for non-decimal input
module seg7_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (nib)
      4'd0: seg = 7'h3F;
      4'd1: seg = 7'h06;
      4'd2: seg = 7'h5B;
      4'd3: seg = 7'h4F;
      4'd4: seg = 7'h66;
      4'd5: seg = 7'h6D;
      4'd6: seg = 7'h7D;
      4'd7: seg = 7'h07;
      4'd8: seg = 7'h7F;
      4'd9: seg = 7'h6F;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scan.sv
// rtl/bcd_display_scan.sv - two-digit 7-segment scan with dead time, blanking and error dash
module bcd_display_scan
  import bcd_disp_pkg::*;
#(
  parameter int SLOT_CYCLES = 1000,
  parameter int GAP_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bcd_in,
  input  logic       load,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       err
);

  localparam int MAX_CYCLES = (SLOT_CYCLES > GAP_CYCLES) ? SLOT_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES);
  localparam logic [CNT_W-1:0] SLOT_LOAD = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       val_q, val_d;
  logic [7:0]       disp_q, disp_d;
  logic             err_q, err_d;
  logic [1:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic       disp_err;
  logic [3:0] dig_nib;
  logic [6:0] dig_seg;

  assign disp_err = nib_bad(disp_q[7:4]) | nib_bad(disp_q[3:0]);
  assign dig_nib  = (state_q == TENS) ? disp_q[7:4] : disp_q[3:0];

  seg7_decode u_dec (
    .nib (dig_nib),
    .seg (dig_seg)
  );

  always_comb begin
    val_d   = val_q;
    err_d   = err_q;
    state_d = state_q;
    cnt_d   = cnt_q - CNT_W'(1);
    disp_d  = disp_q;
    an_d    = AN_OFF;
    seg_d   = SEG_BLANK;

    if (load) begin
      val_d = bcd_in;
      err_d = nib_bad(bcd_in[7:4]) | nib_bad(bcd_in[3:0]);
    end

    // disp_q only refreshes on slot entry, so a digit is stable for its whole slot
    if (cnt_q == '0) begin
      case (state_q)
        ONES:  begin state_d = GAP_A; cnt_d = GAP_LOAD; end
        GAP_A: begin state_d = TENS;  cnt_d = SLOT_LOAD; disp_d = val_q; end
        TENS:  begin state_d = GAP_B; cnt_d = GAP_LOAD; end
        GAP_B: begin state_d = ONES;  cnt_d = SLOT_LOAD; disp_d = val_q; end
      endcase
    end

    case (state_q)
      ONES: begin
        an_d  = AN_ONES;
        seg_d = disp_err ? SEG_DASH : dig_seg;
      end
      TENS: begin
        if (disp_err) begin
          an_d  = AN_TENS;
          seg_d = SEG_DASH;
        end else if (disp_q[7:4] != 4'd0) begin
          an_d  = AN_TENS;
          seg_d = dig_seg;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ONES;
      cnt_q   <= SLOT_LOAD;
      val_q   <= 8'h00;
      disp_q  <= 8'h00;
      err_q   <= 1'b0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      disp_q  <= disp_d;
      err_q   <= err_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign err = err_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// tb/tb_bcd_display_scan.sv - directed scoreboard bench for bcd_display_scan (8-cycle slots, 2-cycle gaps)
module tb_bcd_display_scan;

  typedef struct packed {
    logic [1:0] an;
    logic [6:0] seg;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] bcd_in;
  logic       load;
  logic [6:0] seg;
  logic [1:0] an;
  logic       err;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  bcd_display_scan #(
    .SLOT_CYCLES (8),
    .GAP_CYCLES  (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bcd_in (bcd_in),
    .load   (load),
    .seg    (seg),
    .an     (an),
    .err    (err)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full 20-cycle scan: 8 ones, 2 gap, 8 tens, 2 gap
  task automatic push_scan(input logic [1:0] o_an, input logic [6:0] o_seg,
                           input logic [1:0] t_an, input logic [6:0] t_seg);
    for (int i = 0; i < 8; i++) sb.push_back('{an: o_an, seg: o_seg});
    for (int i = 0; i < 2; i++) sb.push_back('{an: 2'b11, seg: 7'h00});
    for (int i = 0; i < 8; i++) sb.push_back('{an: t_an, seg: t_seg});
    for (int i = 0; i < 2; i++) sb.push_back('{an: 2'b11, seg: 7'h00});
  endtask

  task automatic run(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $error("FAIL sb_empty observed=0 expected=1");
      end else begin
        e = sb.pop_front();
        chk("an", 8'(an), 8'(e.an));
        chk("seg", 8'(seg), 8'(e.seg));
        chk("an_both_low", 8'(an == 2'b00), 8'h00);
      end
    end
  endtask

  task automatic load_one(input logic [7:0] v);
    load   = 1'b1;
    bcd_in = v;
    run(1);
    load   = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    load   = 1'b0;
    bcd_in = 8'h00;

    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_an", 8'(an), 8'h03);
      chk("rst_seg", 8'(seg), 8'h00);
      chk("rst_err", 8'(err), 8'h00);
    end
    rst = 1'b0;

    push_scan(2'b10, 7'h3F, 2'b11, 7'h00);
    run(18);
    load_one(8'h42);
    chk("err_42", 8'(err), 8'h00);
    run(1);

    push_scan(2'b10, 7'h5B, 2'b01, 7'h66);
    run(18);
    load_one(8'h07);
    run(1);

    push_scan(2'b10, 7'h07, 2'b11, 7'h00);
    run(18);
    chk("err_before_ff", 8'(err), 8'h00);
    load_one(8'hFF);
    chk("err_ff", 8'(err), 8'h01);
    run(1);

    push_scan(2'b10, 7'h40, 2'b01, 7'h40);
    run(18);
    load_one(8'h15);
    chk("err_cleared", 8'(err), 8'h00);
    run(1);

    push_scan(2'b10, 7'h6D, 2'b01, 7'h06);
    run(18);
    load_one(8'h42);
    run(1);

    push_scan(2'b10, 7'h5B, 2'b01, 7'h6F);
    run(2);
    load_one(8'h99);
    chk("err_99", 8'(err), 8'h00);
    run(16);

    push_scan(2'b10, 7'h6F, 2'b01, 7'h6F);
    run(12);
    sb.delete();

    rst    = 1'b1;
    load   = 1'b1;
    bcd_in = 8'hA7;
    @(posedge clk);
    #1;
    chk("mid_rst_an", 8'(an), 8'h03);
    chk("mid_rst_seg", 8'(seg), 8'h00);
    chk("mid_rst_err", 8'(err), 8'h00);
    rst  = 1'b0;
    load = 1'b0;

    push_scan(2'b10, 7'h3F, 2'b11, 7'h00);
    run(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
